// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
// Items shared by the eight-digit display scanner and its segment decoder:
//   state_t    - scanner states (OFF / DRIVE / GAP)
//   NDIG       - number of digits scanned per frame
//   BLANK_AN   - digit-select value with every digit off (active-low)
//   BLANK_SEG  - segment value with every segment off (active-low)
//   seg_font() - active-high segment pattern for one hex nibble
// Segment bit order is {a,b,c,d,e,f,g,dp}, so '0' is 8'hFC and '8' is 8'hFE.
// ---------------------------------------------------------------------------
package seg_scan_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int         NDIG      = 8;
    localparam logic [7:0] BLANK_AN  = 8'hFF;
    localparam logic [7:0] BLANK_SEG = 8'hFF;

    function automatic logic [7:0] seg_font(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'hFC;
            4'h1: pat = 8'h60;
            4'h2: pat = 8'hDA;
            4'h3: pat = 8'hF2;
            4'h4: pat = 8'h66;
            4'h5: pat = 8'hB6;
            4'h6: pat = 8'hBE;
            4'h7: pat = 8'hE0;
            4'h8: pat = 8'hFE;
            4'h9: pat = 8'hF6;
            4'hA: pat = 8'hEE;
            4'hB: pat = 8'h3E;
            4'hC: pat = 8'h9C;
            4'hD: pat = 8'h7A;
            4'hE: pat = 8'h9E;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_dec.sv
// ---------------------------------------------------------------------------
// seg_scan_dec
// Shared hex-to-seven-segment decoder, purely combinational.
// Ports:
//   nib  in  4  hex digit to display
//   en   in  1  decoder enable; 0 forces every segment off
//   seg  out 8  segment pattern, active-low, {a,b,c,d,e,f,g,dp}
// ---------------------------------------------------------------------------
module seg_scan_dec
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       en,
    output logic [7:0] seg
);

    always_comb begin
        seg = en ? ~seg_font(nib) : BLANK_SEG;
    end

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
// Time-multiplexed driver for an eight-digit common-anode display. Each digit
// owns a slot of DIV cycles: DIV-DEAD cycles driven, then DEAD cycles of dead
// time with every digit off. A new word is taken through a valid/ready
// handshake into a pending register and only committed to the displayed
// register at a frame boundary (or straight away while the scanner is off),
// so a frame never mixes two words.
// Ports:
//   clk         in  1   clock, rising edge
//   rst         in  1   synchronous active-high reset
//   en          in  1   display enable; 0 blanks and parks the scanner
//   ld_valid    in  1   a new display word is offered
//   ld_data     in  32  eight hex nibbles, digit k = ld_data[4k+3:4k]
//   ld_mask     in  8   per-digit enable captured with ld_data
//   lzb         in  1   leading-zero blanking, used live
//   ld_ready    out 1   a word can be accepted
//   an          out 8   digit select, active-low
//   seg_out     out 8   segment pattern, active-low
//   frame_done  out 1   one-cycle pulse after each completed 8-digit frame
// ---------------------------------------------------------------------------
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int DIV  = 1000,
    parameter int DEAD = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic [7:0]  ld_mask,
    input  logic        lzb,
    output logic        ld_ready,
    output logic [7:0]  an,
    output logic [7:0]  seg_out,
    output logic        frame_done
);

    localparam logic [15:0] DRIVE_LAST = 16'(DIV - DEAD - 1);
    localparam logic [15:0] SLOT_LAST  = 16'(DIV - 1);
    localparam int          IDX_W      = $clog2(NDIG);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        cnt;

    logic [31:0]        act_data;
    logic [7:0]         act_mask;
    logic [31:0]        pend_data;
    logic [7:0]         pend_mask;
    logic               pend_valid;

    logic               frame_end;
    logic               transfer;
    logic               commit;
    logic               zero_tail;
    logic               blanked;
    logic               dec_en;
    logic [3:0]         nib;
    logic [7:0]         an_next;
    logic [7:0]         seg_dec;

    // ---- next-state logic ----
    always_comb begin
        // NOTE: assign a default before any branch so every path drives the
        // signal; a missing branch would otherwise infer a latch.
        state_next = state;
        if (!en) begin
            state_next = OFF;
        end else begin
            case (state)
                OFF:     state_next = DRIVE;
                DRIVE:   if (cnt == DRIVE_LAST) state_next = GAP;
                GAP:     if (cnt == SLOT_LAST)  state_next = DRIVE;
                default: state_next = OFF;
            endcase
        end
    end

    // ---- state register with digit index and slot counter ----
    // The counter runs straight through DRIVE into GAP and only clears on
    // entry to DRIVE or OFF, so one count spans the whole slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of the others, matching flip-flop behaviour.
            state <= state_next;
            if (state_next == OFF) begin
                idx <= '0;
                cnt <= '0;
            end else if (state_next == DRIVE && state != DRIVE) begin
                cnt <= '0;
                if (state == GAP) idx <= idx + 1'b1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // ---- output / datapath decode ----
    always_comb begin
        frame_end = (state == GAP) && (state_next == DRIVE) && (idx == IDX_W'(NDIG - 1));
        nib       = act_data[{idx, 2'b00} +: 4];
        // Digits idx..7 all zero: the current digit is a leading zero.
        zero_tail = (act_data >> {idx, 2'b00}) == 32'd0;
        blanked   = !act_mask[idx] || (lzb && (idx != '0) && zero_tail);
        dec_en    = (state == DRIVE) && !blanked;
        an_next   = dec_en ? ~(8'b1 << idx) : BLANK_AN;
    end

    seg_scan_dec u_dec (
        .nib (nib),
        .en  (dec_en),
        .seg (seg_dec)
    );

    // ---- load handshake ----
    // ready is low exactly while a word waits in the pending register, so a
    // capture and a commit can never happen on the same edge.
    assign ld_ready = !pend_valid;
    assign transfer = ld_valid && ld_ready;
    assign commit   = pend_valid && (frame_end || state == OFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_mask  <= '0;
            act_data   <= '0;
            act_mask   <= 8'hFF;
        end else if (transfer) begin
            pend_valid <= 1'b1;
            pend_data  <= ld_data;
            pend_mask  <= ld_mask;
        end else if (commit) begin
            pend_valid <= 1'b0;
            act_data   <= pend_data;
            act_mask   <= pend_mask;
        end
    end

    // ---- registered display outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= BLANK_AN;
            seg_out    <= BLANK_SEG;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg_out    <= seg_dec;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
// Self-checking bench for seg_scan with DIV=4, DEAD=1. A reference model
// tracks time since the scanner entered DRIVE and derives digit, slot phase,
// blanking, frame end and commit from that count with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_seg_scan;

    localparam int DIV   = 4;
    localparam int DEAD  = 1;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic [7:0]  ld_mask = 8'hFF;
    logic        lzb = 1'b0;
    logic        ld_ready;
    logic [7:0]  an;
    logic [7:0]  seg_out;
    logic        frame_done;

    seg_scan #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_mask    (ld_mask),
        .lzb        (lzb),
        .ld_ready   (ld_ready),
        .an         (an),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // ---- reference model state ----
    bit          m_on;
    int          m_t;
    logic [31:0] m_act_d;
    logic [7:0]  m_act_m;
    bit          m_pend_v;
    logic [31:0] m_pend_d;
    logic [7:0]  m_pend_m;
    logic [7:0]  m_an;
    logic [7:0]  m_seg;
    logic        m_fd;
    logic        m_rdy;

    function automatic logic [7:0] font(input logic [3:0] n);
        logic [7:0] tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        return tbl[n];
    endfunction

    // Expected outputs after the coming edge, from pre-edge model state and
    // the inputs that edge will sample.
    task automatic model_step();
        int  d, pos;
        bit  drive, blank, fe, commit, xfer;
        logic [31:0] tail;
        if (rst) begin
            m_on = 0; m_t = 0;
            m_act_d = '0; m_act_m = 8'hFF;
            m_pend_v = 0; m_pend_d = '0; m_pend_m = '0;
            m_an = 8'hFF; m_seg = 8'hFF; m_fd = 1'b0; m_rdy = 1'b1;
            return;
        end
        d     = m_on ? (m_t / DIV) % 8 : 0;
        pos   = m_on ? m_t % DIV : 0;
        drive = m_on && (pos < DIV - DEAD);
        tail  = m_act_d >> (4 * d);
        blank = !m_act_m[d] || (lzb && d > 0 && tail == 0);
        if (drive && !blank) begin
            m_an  = ~(8'b1 << d);
            m_seg = ~font(m_act_d[4*d +: 4]);
        end else begin
            m_an  = 8'hFF;
            m_seg = 8'hFF;
        end
        fe     = m_on && en && d == 7 && pos == DIV - 1;
        m_fd   = fe;
        commit = m_pend_v && (fe || !m_on);
        xfer   = ld_valid && !m_pend_v;
        if (xfer) begin
            m_pend_v = 1; m_pend_d = ld_data; m_pend_m = ld_mask;
        end else if (commit) begin
            m_pend_v = 0; m_act_d = m_pend_d; m_act_m = m_pend_m;
        end
        m_rdy = !m_pend_v;
        if (!en) begin
            m_on = 0; m_t = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    // Advance one clock; outputs are then stable at the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Offer a word until the DUT takes it (no comparisons here).
    task automatic do_load(input logic [31:0] d, input logic [7:0] m, output bit ok);
        bit was;
        ld_valid = 1'b1; ld_data = d; ld_mask = m;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            was = ld_ready;
            tick();
            if (was) begin ok = 1; break; end
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_done) begin ok = 1; break; end
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; ld_valid = 1'b1; ld_data = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {8'hFF, 8'hFF, 1'b0, 1'b1})
                $display("FAIL reset_values cyc=%0d got an=%h seg=%h fd=%b rdy=%b want FF/FF/0/1",
                         cyc, an, seg_out, frame_done, ld_ready);
            else n_pass++;
        end
        rst = 1'b0; en = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_reset cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
        end
    endtask

    // No word loaded, leading-zero blanking on: only digit 0 shows '0'.
    task automatic test_blank_zero();
        int k = 0;
        lzb = 1'b1; en = 1'b1;
        tick();                                  // edge that enters DRIVE
        while (k < 40) begin
            tick();
            k++;
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_blank_zero cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (k == 1) begin
                n_total++;
                if ({an, seg_out} !== {8'hFE, 8'h03})
                    $display("FAIL digit0_zero got an=%h seg=%h want FE/03", an, seg_out);
                else n_pass++;
            end
            if (frame_done) break;
        end
        n_total++;
        if (k !== 32)
            $display("FAIL first_frame_done got %0d cycles want 32", k);
        else n_pass++;
    endtask

    // 12345678 shown in the next full frame; ready low until that frame ends.
    task automatic test_load_digits();
        bit ok;
        logic [7:0] rec [8];
        int d;
        lzb = 1'b0;
        do_load(32'h1234_5678, 8'hFF, ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_load cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (frame_done) begin ok = 1; break; end
        end
        n_total++;
        if (!ok) $display("FAIL load_commit_timeout got no frame_done want pulse");
        else n_pass++;
        for (int i = 0; i < 8; i++) rec[i] = 8'hFF;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_frame cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            for (d = 0; d < 8; d++) if (an == ~(8'b1 << d)) rec[d] = seg_out;
        end
        n_total++;
        if ({rec[0], rec[1], rec[7]} !== {8'h01, 8'h1F, 8'h9F})
            $display("FAIL digits_8_7_1 got %h %h %h want 01 1F 9F", rec[0], rec[1], rec[7]);
        else n_pass++;
    endtask

    // 000000A5 with blanking: two digits lit; dropping lzb mid-frame lights zeros.
    task automatic test_lzb();
        bit ok;
        int lit;
        bit zero_seen;
        lzb = 1'b1;
        do_load(32'h0000_00A5, 8'hFF, ok);
        wait_frame(ok);
        n_total++;
        if (!ok) $display("FAIL lzb_commit_timeout got no frame_done want pulse");
        else n_pass++;
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_lzb cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (an != 8'hFF) lit++;
        end
        // two digits, DIV-DEAD driven cycles each
        n_total++;
        if (lit !== 2 * (DIV - DEAD))
            $display("FAIL lzb_lit_cycles got %0d want %0d", lit, 2 * (DIV - DEAD));
        else n_pass++;
        zero_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) lzb = 1'b0;
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_lzb_toggle cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (an == 8'hF7 && seg_out == 8'h03) zero_seen = 1;
        end
        n_total++;
        if (!zero_seen) $display("FAIL lzb_off_digit3 got no '0' on digit 3 want shown");
        else n_pass++;
    endtask

    // Second word offered right after the first is held off until commit.
    task automatic test_back_to_back();
        bit ok, was;
        int held = 0;
        lzb = 1'b0;
        do_load(32'h1111_1111, 8'hFF, ok);
        ld_valid = 1'b1; ld_data = 32'h2222_2222; ld_mask = 8'hFF;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            was = ld_ready;
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_b2b cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (was) begin ok = 1; break; end
            held++;
        end
        ld_valid = 1'b0;
        n_total++;
        if (!ok || held < 1)
            $display("FAIL b2b_holdoff got accepted=%0d held=%0d want 1 and >=1", ok, held);
        else n_pass++;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_b2b_after cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
        end
    endtask

    // en dropped in digit 3 DRIVE, load while off, restart at digit 0.
    task automatic test_en_drop();
        bit ok;
        lzb = 1'b0; en = 1'b1;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (m_on && (m_t / DIV) % 8 == 3 && m_t % DIV == 0) begin ok = 1; break; end
            tick();
        end
        tick();                                   // digit 3 DRIVE visible
        n_total++;
        if (!ok) $display("FAIL en_drop_reach_d3 got timeout want digit 3");
        else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_en_drop cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if (an !== 8'hFF) $display("FAIL en_drop_blank got an=%h want FF", an);
                else n_pass++;
            end
        end
        ld_valid = 1'b1; ld_data = 32'h0000_0009; ld_mask = 8'hFF;
        tick();
        ld_valid = 1'b0;
        n_total++;
        if (ld_ready !== 1'b0) $display("FAIL off_capture got rdy=%b want 0", ld_ready);
        else n_pass++;
        tick();
        n_total++;
        if (ld_ready !== 1'b1) $display("FAIL off_commit got rdy=%b want 1", ld_ready);
        else n_pass++;
        en = 1'b1;
        tick();
        tick();
        n_total++;
        if ({an, seg_out} !== {8'hFE, 8'h09})
            $display("FAIL restart_digit0 got an=%h seg=%h want FE/09", an, seg_out);
        else n_pass++;
    endtask

    // Reset with a word pending: the word is dropped and never shown.
    task automatic test_rst_pending();
        bit ok, bad;
        lzb = 1'b0; en = 1'b1;
        do_load(32'hDEAD_BEEF, 8'hFF, ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({an, seg_out, frame_done, ld_ready} !== {8'hFF, 8'hFF, 1'b0, 1'b1})
            $display("FAIL rst_pending_values got %h/%h/%b/%b want FF/FF/0/1",
                     an, seg_out, frame_done, ld_ready);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_rst_pending cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (an != 8'hFF && seg_out != 8'h03) bad = 1;
        end
        n_total++;
        if (bad) $display("FAIL rst_pending_discard got non-zero digit want all '0'");
        else n_pass++;
    endtask

    // Random en / lzb / loads / occasional reset against the model.
    task automatic test_random();
        bit was;
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 400) == 0;
            if (en ? ($urandom % 90 == 0) : ($urandom % 6 == 0)) en = ~en;
            if ($urandom % 16 == 0) lzb = $urandom;
            if (!ld_valid && ($urandom % 8 == 0)) begin
                ld_valid = 1'b1;
                ld_data  = $urandom;
                ld_mask  = ($urandom % 3 == 0) ? 8'($urandom) : 8'hFF;
                if ($urandom % 2) ld_data = ld_data & 32'h0000_0FFF;
            end
            was = ld_ready;
            tick();
            n_total++;
            if ({an, seg_out, frame_done, ld_ready} !== {m_an, m_seg, m_fd, m_rdy})
                $display("FAIL model_random cyc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         cyc, an, seg_out, frame_done, ld_ready, m_an, m_seg, m_fd, m_rdy);
            else n_pass++;
            if (ld_valid && was && !rst) ld_valid = 1'b0;
        end
        rst = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blank_zero();
        test_load_digits();
        test_lzb();
        test_back_to_back();
        test_en_drop();
        test_rst_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
